// File: rtl/script_executor.sv
// Script interpreter: fetches 16-bit instructions from ScriptMem and drives the
// per-player command bytes (operate/target) that SendData serialises.
module script_executor #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic              uart_clk,
   input  logic              reset,
   input  logic              run,
   input  logic              script_mode,
   input  logic [15:0]       script,
   input  logic              ms_tick,
   input  logic              in_front,
   input  logic              has_item,
   input  logic              machine_busy,
   input  logic              machine_has_item,
   output logic [ADDR_W-1:0] pc,
   output logic [7:0]        target_data,
   output logic [7:0]        operate_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HOLD,
      S_WAITMS,
      S_WAITC,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [7:0]          tgt_q, tgt_d;
   logic [7:0]          op_q, op_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [11:0]         ms_q, ms_d;
   logic [2:0]          cond_q, cond_d;

   logic [ADDR_W-1:0]   pc_inc;
   logic [3:0]          opcode;
   logic [4:0]          act_oh;
   logic                cond_sig;

   always_ff @(posedge uart_clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         tgt_q   <= '0;
         op_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= '0;
         ms_q    <= '0;
         cond_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         hold_q  <= hold_d;
         ms_q    <= ms_d;
         cond_q  <= cond_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      tgt_d    = tgt_q;
      op_d     = op_q;
      err_d    = err_q;
      hold_d   = hold_q;
      ms_d     = ms_q;
      cond_d   = cond_q;
      pc_inc   = pc_q + 1'b1;
      opcode   = script[15:12];
      act_oh   = 5'b00001 << script[2:0];
      cond_sig = 1'b0;

      // Wait condition is latched at EXEC so WAITC does not depend on script staying stable.
      case (cond_q[1:0])
         2'd0:    cond_sig = in_front;
         2'd1:    cond_sig = has_item;
         2'd2:    cond_sig = machine_busy;
         default: cond_sig = machine_has_item;
      endcase

      if (state_q != S_IDLE && (!run || script_mode)) begin
         state_d = S_IDLE;
         pc_d    = '0;
         tgt_d   = '0;
         op_d    = '0;
         err_d   = 1'b0;
         hold_d  = '0;
         ms_d    = '0;
         cond_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run && !script_mode) begin
                  state_d = S_FETCH;
                  pc_d    = '0;
                  err_d   = 1'b0;
               end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
               case (opcode)
                  4'h0: begin
                     pc_d    = pc_inc;
                     state_d = S_FETCH;
                  end
                  4'h1: begin
                     tgt_d   = {script[5:0], 2'b11};
                     op_d    = 8'h0C;
                     hold_d  = '0;
                     state_d = S_HOLD;
                  end
                  4'h2: begin
                     if (script[2:0] <= 3'd4) begin
                        op_d    = {1'b0, act_oh, 2'b10};
                        hold_d  = '0;
                        state_d = S_HOLD;
                     end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                     end
                  end
                  4'h3: begin
                     if (script[11:0] == 12'd0) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                     end else begin
                        ms_d    = script[11:0];
                        state_d = S_WAITMS;
                     end
                  end
                  4'h4: begin
                     cond_d  = script[2:0];
                     state_d = S_WAITC;
                  end
                  4'h5: begin
                     pc_d    = script[ADDR_W-1:0];
                     state_d = S_FETCH;
                  end
                  4'hF: state_d = S_DONE;
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end
               endcase
            end
            S_HOLD: begin
               if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                  op_d    = '0;
                  hold_d  = '0;
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            S_WAITMS: begin
               if (ms_tick) begin
                  if (ms_q == 12'd1) begin
                     ms_d    = '0;
                     pc_d    = pc_inc;
                     state_d = S_FETCH;
                  end else begin
                     ms_d = ms_q - 1'b1;
                  end
               end
            end
            S_WAITC: begin
               if (cond_sig == cond_q[2]) begin
                  pc_d    = pc_inc;
                  state_d = S_FETCH;
               end
            end
            S_DONE:  op_d = '0;
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   assign pc           = pc_q;
   assign target_data  = tgt_q;
   assign operate_data = op_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_script_executor.sv
// Bench for script_executor: registered ROM model, operate_data sequence scoreboard,
// and directed checks of wait, jump, abort and error behaviour.
module tb_script_executor;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        script_mode;
   logic [15:0] script;
   logic        ms_tick;
   logic        in_front;
   logic        has_item;
   logic        machine_busy;
   logic        machine_has_item;
   logic [7:0]  pc;
   logic [7:0]  target_data;
   logic [7:0]  operate_data;
   logic        busy;
   logic        done;
   logic        err;

   logic [15:0] mem [0:255];

   typedef struct {
      logic [7:0] val;
      int         len;
   } op_exp_t;

   op_exp_t     op_q[$];
   op_exp_t     cur;
   bit          have_cur = 1'b0;
   logic [7:0]  last_op  = 8'h00;
   int          run_len  = 0;
   int          n_cmp    = 0;
   int          n_bad    = 0;

   always #5 clk = ~clk;

   script_executor #(
      .ADDR_W      (8),
      .HOLD_CYCLES (16)
   ) dut (
      .uart_clk         (clk),
      .reset            (reset),
      .run              (run),
      .script_mode      (script_mode),
      .script           (script),
      .ms_tick          (ms_tick),
      .in_front         (in_front),
      .has_item         (has_item),
      .machine_busy     (machine_busy),
      .machine_has_item (machine_has_item),
      .pc               (pc),
      .target_data      (target_data),
      .operate_data     (operate_data),
      .busy             (busy),
      .done             (done),
      .err              (err)
   );

   // ScriptMem: one cycle of read latency
   always @(posedge clk) script <= mem[pc];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_op(input logic [7:0] v, input int len);
      op_exp_t e;
      e.val = v;
      e.len = len;
      op_q.push_back(e);
   endtask

   // Scoreboard: every operate_data change is popped and compared, including run length.
   always @(negedge clk) begin
      if (operate_data === last_op) begin
         run_len++;
      end else begin
         if (have_cur && cur.len != 0) chk("op_len", run_len, cur.len);
         if (op_q.size() == 0) begin
            chk("op_unexp", operate_data, last_op);
            have_cur = 1'b0;
         end else begin
            cur      = op_q.pop_front();
            have_cur = 1'b1;
            chk("op_val", operate_data, cur.val);
         end
         last_op = operate_data;
         run_len = 1;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
   endtask

   task automatic start();
      run = 1'b1;
   endtask

   task automatic stop();
      run = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_done(input int max, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1'b1;
      end
      chk(tag, ok, 1);
   endtask

   task automatic wait_pc(input logic [7:0] v, input int max, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (pc === v) ok = 1'b1;
      end
      chk(tag, ok, 1);
   endtask

   task automatic wait_op(input logic [7:0] v, input int max, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (operate_data === v) ok = 1'b1;
      end
      chk(tag, ok, 1);
   endtask

   task automatic pulse_tick();
      ms_tick = 1'b1;
      @(negedge clk);
      ms_tick = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset            = 1'b0;
      run              = 1'b1;
      script_mode      = 1'b0;
      ms_tick          = 1'b0;
      in_front         = 1'b0;
      has_item         = 1'b0;
      machine_busy     = 1'b0;
      machine_has_item = 1'b0;
      clear_mem();

      repeat (3) @(negedge clk);
      chk("rst_pc", pc, 0);
      chk("rst_op", operate_data, 0);
      chk("rst_tgt", target_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);

      // MOVE 5, ACT interact, END
      mem[0] = 16'h1005; mem[1] = 16'h2002; mem[2] = 16'hF000;
      push_op(8'h0C, 16); push_op(8'h00, 2); push_op(8'h12, 16); push_op(8'h00, 0);
      reset = 1'b1;
      wait_done(80, "t2_done_to");
      chk("t2_done", done, 1);
      chk("t2_pc", pc, 2);
      chk("t2_op", operate_data, 0);
      chk("t2_tgt", target_data, 8'h17);
      chk("t2_busy", busy, 0);
      chk("t2_err", err, 0);
      stop();
      chk("stop_pc", pc, 0);
      chk("stop_tgt", target_data, 0);
      chk("stop_done", done, 0);

      // ACT put and throw keep the MOVE target
      clear_mem();
      mem[0] = 16'h1005; mem[1] = 16'h2001; mem[2] = 16'h2004; mem[3] = 16'hF000;
      push_op(8'h0C, 16); push_op(8'h00, 2); push_op(8'h0A, 16); push_op(8'h00, 2);
      push_op(8'h42, 16); push_op(8'h00, 0);
      start();
      wait_done(120, "act_done_to");
      chk("act_pc", pc, 3);
      chk("act_tgt", target_data, 8'h17);
      stop();

      // WAITMS 3
      clear_mem();
      mem[0] = 16'h3003; mem[1] = 16'hF000;
      start();
      repeat (5) @(negedge clk);
      pulse_tick(); repeat (8) @(negedge clk);
      pulse_tick(); repeat (8) @(negedge clk);
      chk("ms_pc_wait", pc, 0);
      chk("ms_busy", busy, 1);
      chk("ms_done_early", done, 0);
      pulse_tick();
      chk("ms_pc_adv", pc, 1);
      chk("ms_done_t1", done, 0);
      @(negedge clk);
      chk("ms_done_t2", done, 0);
      @(negedge clk);
      chk("ms_done_t3", done, 1);
      stop();

      // WAITMS 0 does not wait
      clear_mem();
      mem[0] = 16'h3000; mem[1] = 16'hF000;
      start();
      repeat (4) @(negedge clk);
      chk("ms0_done_early", done, 0);
      @(negedge clk);
      chk("ms0_done", done, 1);
      chk("ms0_pc", pc, 1);
      stop();

      // WAITC has_item == 1
      clear_mem();
      mem[0] = 16'h4005; mem[1] = 16'hF000;
      start();
      repeat (40) @(negedge clk);
      chk("wc_pc_wait", pc, 0);
      chk("wc_busy", busy, 1);
      has_item = 1'b1;
      @(negedge clk);
      chk("wc_pc_adv", pc, 1);
      wait_done(10, "wc_done_to");
      stop();
      has_item = 1'b0;

      // WAITC machine_has_item == 0
      clear_mem();
      mem[0] = 16'h4003; mem[1] = 16'hF000;
      machine_has_item = 1'b1;
      start();
      repeat (10) @(negedge clk);
      chk("wc0_pc_wait", pc, 0);
      machine_has_item = 1'b0;
      @(negedge clk);
      chk("wc0_pc_adv", pc, 1);
      stop();

      // JMP 255, NOP at 255 wraps to 0 and loops
      clear_mem();
      mem[0] = 16'h50FF; mem[255] = 16'h0000;
      start();
      wait_pc(8'hFF, 10, "jmp_255");
      wait_pc(8'h00, 10, "wrap_0");
      chk("wrap_busy", busy, 1);
      wait_pc(8'hFF, 10, "loop_255");
      chk("loop_busy", busy, 1);
      chk("loop_done", done, 0);
      stop();

      // script_mode pulse mid-HOLD aborts
      clear_mem();
      mem[0] = 16'h1005; mem[1] = 16'hF000;
      push_op(8'h0C, 0); push_op(8'h00, 0);
      start();
      wait_op(8'h0C, 10, "ab_op_to");
      repeat (5) @(negedge clk);
      script_mode = 1'b1;
      @(negedge clk);
      chk("ab_op", operate_data, 0);
      chk("ab_pc", pc, 0);
      chk("ab_tgt", target_data, 0);
      chk("ab_busy", busy, 0);
      script_mode = 1'b0;
      stop();

      // Illegal opcode 7
      clear_mem();
      mem[0] = 16'h7000;
      start();
      wait_done(10, "ill_done_to");
      chk("ill_err", err, 1);
      chk("ill_done", done, 1);
      stop();
      chk("ill_err_clr", err, 0);

      // Illegal ACT index 5
      clear_mem();
      mem[0] = 16'h2005;
      start();
      wait_done(10, "illa_done_to");
      chk("illa_err", err, 1);
      chk("illa_op", operate_data, 0);
      stop();

      repeat (2) @(negedge clk);
      chk("op_left", op_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
